// File: rtl/rr_pulse_pkg.sv
// ============================================================================
// Module      : rr_pulse_pkg
// Description : Shared types and sizing helper for the index-to-pulse generator.
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

package rr_pulse_pkg;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        HIGH = 2'd1,
        GAP  = 2'd2
    } pulse_state_t;

    // The counter is wide enough to hold the larger of the two reload values.
    function automatic int cnt_width(input int pulse_width, input int gap_width);
        int longest;
        longest = (pulse_width > gap_width) ? pulse_width : gap_width;
        return (longest < 1) ? 1 : $clog2(longest + 1);
    endfunction

endpackage

`default_nettype wire

// File: rtl/rr_pulse_channel.sv
// ============================================================================
// Module      : rr_pulse_channel
// Description : One output channel: IDLE -> HIGH -> GAP -> IDLE with a reload
//               down-counter. Optional macro: RR_PULSE_RETRIGGER_EN.
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module rr_pulse_channel
    import rr_pulse_pkg::*;
#(
    parameter int PULSE_WIDTH = 4,
    parameter int GAP_WIDTH   = 1
)
(
    input  logic clk,
    input  logic rstn,
    input  logic start,
    output logic pulse,
    output logic busy,
    output logic can_accept
);

    localparam int               CNT_W     = cnt_width(PULSE_WIDTH, GAP_WIDTH);
    localparam logic [CNT_W-1:0] HIGH_LOAD = CNT_W'(PULSE_WIDTH - 1);
    localparam logic [CNT_W-1:0] GAP_LOAD  = CNT_W'(GAP_WIDTH - 1);
    localparam logic [CNT_W-1:0] CNT_ONE   = CNT_W'(1);

    pulse_state_t     state;
    pulse_state_t     state_next;
    logic [CNT_W-1:0] cnt;
    logic [CNT_W-1:0] cnt_next;

    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            state <= IDLE;
            cnt   <= '0;
            pulse <= 1'b0;
        end else begin
            state <= state_next;
            cnt   <= cnt_next;
            // Output register follows the next state so it lines up with the FSM.
            pulse <= (state_next == HIGH);
        end
    end

    always_comb begin
        state_next = state;
        cnt_next   = cnt;
        case (state)
            IDLE: begin
                if (start) begin
                    state_next = HIGH;
                    cnt_next   = HIGH_LOAD;
                end
            end
            HIGH: begin
`ifdef RR_PULSE_RETRIGGER_EN
                if (start) begin
                    cnt_next = HIGH_LOAD;
                end else
`endif
                if (cnt == '0) begin
                    state_next = GAP;
                    cnt_next   = GAP_LOAD;
                end else begin
                    cnt_next = cnt - CNT_ONE;
                end
            end
            GAP: begin
                if (cnt == '0) begin
                    state_next = IDLE;
                end else begin
                    cnt_next = cnt - CNT_ONE;
                end
            end
            default: begin
                state_next = IDLE;
                cnt_next   = '0;
            end
        endcase
    end

    assign busy = (state != IDLE);

`ifdef RR_PULSE_RETRIGGER_EN
    assign can_accept = (state == IDLE) || (state == HIGH);
`else
    assign can_accept = (state == IDLE);
`endif

endmodule

`default_nettype wire

// File: rtl/rr_index_pulse_gen.sv
// ============================================================================
// Module      : rr_index_pulse_gen
// Description : Valid/ready stream of bit indices to per-bit pulses with a
//               guaranteed low gap. Optional macro: RR_PULSE_RETRIGGER_EN.
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module rr_index_pulse_gen
    import rr_pulse_pkg::*;
#(
    parameter  int DATA_WIDTH    = 8,
    parameter  int PULSE_WIDTH   = 4,
    parameter  int GAP_WIDTH     = 1,
    localparam int LB_DATA_WIDTH = $clog2(DATA_WIDTH)
)
(
    input  logic                     clk,
    input  logic                     rstn,
    input  logic [LB_DATA_WIDTH-1:0] index,
    input  logic                     valid,
    output logic                     ready,
    output logic [DATA_WIDTH-1:0]    out_data,
    output logic [DATA_WIDTH-1:0]    busy,
    output logic                     drop
);

    localparam int                     SLOTS  = 1 << LB_DATA_WIDTH;
    localparam logic [LB_DATA_WIDTH:0] DW_EXT = (LB_DATA_WIDTH + 1)'(DATA_WIDTH);

    logic [DATA_WIDTH-1:0] chan_ready;
    logic [DATA_WIDTH-1:0] start;
    logic [SLOTS-1:0]      slot_ready;
    logic                  in_range;
    logic                  accept;

    assign in_range = ({1'b0, index} < DW_EXT);

    // Unused index codes always report ready so they can be accepted and dropped.
    for (genvar i = 0; i < SLOTS; i++) begin : g_slot
        if (i < DATA_WIDTH) begin : g_chan_slot
            assign slot_ready[i] = chan_ready[i];
        end else begin : g_pad_slot
            assign slot_ready[i] = 1'b1;
        end
    end

    assign ready  = slot_ready[index];
    assign accept = valid & ready;

    for (genvar i = 0; i < DATA_WIDTH; i++) begin : g_chan
        assign start[i] = accept & in_range & (index == LB_DATA_WIDTH'(i));

        rr_pulse_channel #(
            .PULSE_WIDTH (PULSE_WIDTH),
            .GAP_WIDTH   (GAP_WIDTH)
        ) u_channel (
            .clk        (clk),
            .rstn       (rstn),
            .start      (start[i]),
            .pulse      (out_data[i]),
            .busy       (busy[i]),
            .can_accept (chan_ready[i])
        );
    end

    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            drop <= 1'b0;
        end else begin
            drop <= accept & ~in_range;
        end
    end

endmodule

`default_nettype wire

// File: tb/tb_rr_index_pulse_gen.sv
// ============================================================================
// Module      : tb_rr_index_pulse_gen
// Description : Self-checking bench for rr_index_pulse_gen (8- and 6-bit builds).
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module tb_rr_index_pulse_gen;

    localparam int PW = 4;
    localparam int GW = 1;
`ifdef RR_PULSE_RETRIGGER_EN
    localparam bit RETRIG = 1'b1;
`else
    localparam bit RETRIG = 1'b0;
`endif

    logic       clk  = 1'b0;
    logic       rstn = 1'b0;
    logic [2:0] index = '0;
    logic       valid = 1'b0;
    logic       ready;
    logic [7:0] out_data;
    logic [7:0] busy;
    logic       drop;

    logic [2:0] index6 = '0;
    logic       valid6 = 1'b0;
    logic       ready6;
    logic [5:0] out6;
    logic [5:0] busy6;
    logic       drop6;

    always #5 clk = ~clk;

    rr_index_pulse_gen #(.DATA_WIDTH(8), .PULSE_WIDTH(PW), .GAP_WIDTH(GW)) u_dut8 (
        .clk(clk), .rstn(rstn), .index(index), .valid(valid), .ready(ready),
        .out_data(out_data), .busy(busy), .drop(drop)
    );

    rr_index_pulse_gen #(.DATA_WIDTH(6), .PULSE_WIDTH(PW), .GAP_WIDTH(GW)) u_dut6 (
        .clk(clk), .rstn(rstn), .index(index6), .valid(valid6), .ready(ready6),
        .out_data(out6), .busy(busy6), .drop(drop6)
    );

    int         checks = 0;
    int         errors = 0;
    int         cyc    = 0;
    int         acc_t[$];
    int         acc_b[$];
    logic [7:0] sb_out[$];
    logic [7:0] sb_busy[$];

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s at %0t: got %h expected %h", tag, $time, got, exp);
        end
    endtask

    // Expected value after edge k, derived from the accept history and pulse timing.
    function automatic logic [7:0] exp_out(input int k);
        logic [7:0] v;
        v = '0;
        foreach (acc_t[i])
            if (k >= acc_t[i] && k <= acc_t[i] + PW - 1) v[acc_b[i]] = 1'b1;
        return v;
    endfunction

    function automatic logic [7:0] exp_busy(input int k);
        logic [7:0] v;
        v = '0;
        foreach (acc_t[i])
            if (k >= acc_t[i] && k <= acc_t[i] + PW + GW - 1) v[acc_b[i]] = 1'b1;
        return v;
    endfunction

    // Called just after edge cyc: drive, check ready, push expectations, then
    // pop and compare after the next edge.
    task automatic drive(input logic v, input logic [2:0] idx);
        logic       exp_rdy;
        logic [7:0] o;
        logic [7:0] b;
        valid = v;
        index = idx;
        #1;
        o = exp_out(cyc);
        b = exp_busy(cyc);
        exp_rdy = !b[idx] || (RETRIG && o[idx]);
        check("ready", {31'd0, ready}, {31'd0, exp_rdy});
        if (v && exp_rdy) begin
            acc_t.push_back(cyc + 1);
            acc_b.push_back(int'(idx));
        end
        sb_out.push_back(exp_out(cyc + 1));
        sb_busy.push_back(exp_busy(cyc + 1));
        @(posedge clk);
        cyc++;
        #1;
        check("out_data", {24'd0, out_data}, {24'd0, sb_out.pop_front()});
        check("busy", {24'd0, busy}, {24'd0, sb_busy.pop_front()});
        check("drop", {31'd0, drop}, 32'd0);
    endtask

    task automatic idle(input int n);
        for (int i = 0; i < n; i++) drive(1'b0, 3'd0);
    endtask

    task automatic restart();
        acc_t.delete();
        acc_b.delete();
        cyc = 0;
    endtask

    initial begin
        repeat (3) @(posedge clk);
        #1;
        rstn = 1'b1;
        check("rst_out", {24'd0, out_data}, 32'd0);
        check("rst_busy", {24'd0, busy}, 32'd0);
        check("rst_drop", {31'd0, drop}, 32'd0);
        check("rst_out6", {26'd0, out6}, 32'd0);
        for (int i = 0; i < 4; i++) begin
            index = 3'(i * 2 + 1);
            #1;
            check("rst_ready", {31'd0, ready}, 32'd1);
        end
        index6 = 3'd7;
        #1;
        check("rst_ready6_oor", {31'd0, ready6}, 32'd1);
        @(posedge clk);
        #1;

        // Single pulse on bit 3
        restart();
        drive(1'b1, 3'd3);
        idle(6);

        // Same bit held valid: blocked through HIGH and GAP, then re-accepted
        restart();
        for (int i = 0; i < 7; i++) drive(1'b1, 3'd3);
        idle(6);

        // Staggered pulses on bits 0,1,2
        restart();
        drive(1'b1, 3'd0);
        drive(1'b1, 3'd1);
        drive(1'b1, 3'd2);
        idle(6);

        // Second request on bit 2 while high: extends only when retriggering
        restart();
        drive(1'b1, 3'd2);
        drive(1'b0, 3'd2);
        drive(1'b1, 3'd2);
        idle(7);

        // Asynchronous reset mid-pulse on bit 5
        restart();
        drive(1'b1, 3'd5);
        drive(1'b0, 3'd0);
        drive(1'b0, 3'd0);
        #2;
        rstn = 1'b0;
        #1;
        check("async_rst_out", {24'd0, out_data}, 32'd0);
        check("async_rst_busy", {24'd0, busy}, 32'd0);
        @(posedge clk);
        #1;
        rstn = 1'b1;
        restart();
        drive(1'b1, 3'd5);
        idle(6);

        // Out-of-range index on the 6-bit build
        index6 = 3'd7;
        valid6 = 1'b1;
        #1;
        check("oor_ready6", {31'd0, ready6}, 32'd1);
        @(posedge clk);
        #1;
        valid6 = 1'b0;
        check("oor_drop6", {31'd0, drop6}, 32'd1);
        check("oor_out6", {26'd0, out6}, 32'd0);
        check("oor_busy6", {26'd0, busy6}, 32'd0);
        index6 = 3'd6;
        @(posedge clk);
        #1;
        check("oor_drop6_clear", {31'd0, drop6}, 32'd0);
        check("oor_ready6_6", {31'd0, ready6}, 32'd1);
        index6 = 3'd5;
        valid6 = 1'b1;
        @(posedge clk);
        #1;
        valid6 = 1'b0;
        check("inr_out6", {26'd0, out6}, 32'h20);
        check("inr_drop6", {31'd0, drop6}, 32'd0);
        #1;
        check("inr_ready6_busy", {31'd0, ready6}, 32'd0);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule

`default_nettype wire
